// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO and its read-side stream controller.
package fifo_pkg;

    localparam int unsigned SKID_DEPTH = 2;

    typedef logic [1:0] occ_t;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry register FIFO; push and pop in the same cycle are both honoured.
module skid_buf2
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output occ_t             count
);

    logic [WIDTH-1:0] ent0_q, ent0_d;
    logic [WIDTH-1:0] ent1_q, ent1_d;
    occ_t             count_q, count_d;
    logic             pop_ok;

    // ent0 is always the head; ent1 only holds data when count is 2
    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        count_d = count_q;
        pop_ok  = pop && (count_q != occ_t'(0));
        case ({push, pop_ok})
            2'b10: begin
                if (count_q == occ_t'(0)) begin
                    ent0_d = push_data;
                end else begin
                    ent1_d = push_data;
                end
                count_d = count_q + occ_t'(1);
            end
            2'b01: begin
                ent0_d  = ent1_q;
                count_d = count_q - occ_t'(1);
            end
            2'b11: begin
                if (count_q == occ_t'(1)) begin
                    ent0_d = push_data;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = push_data;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= '0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            count_q <= count_d;
        end
    end

    assign head  = ent0_q;
    assign count = count_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side FIFO controller: issues rd_en, hides the 1-cycle read latency and emits a
// valid/ready stream framed into bursts of BURST_LEN words.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned BURST_LEN = 16
)
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             drain_en,
    input  logic                             fifo_empty,
    input  logic [WIDTH-1:0]                 fifo_data_out,
    output logic                             fifo_rd_en,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WIDTH-1:0]                 out_data,
    output logic                             out_last,
    output logic [$clog2(BURST_LEN+1)-1:0]   beat_cnt
);

    localparam int unsigned     CNT_W     = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    logic             in_flight_q, in_flight_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    occ_t             buf_count;
    occ_t             occ;
    logic             pop;
    logic [WIDTH-1:0] buf_head;

    // A pop frees a slot in the same edge, so reads may continue at full occupancy
    always_comb begin
        occ         = buf_count + occ_t'(in_flight_q);
        pop         = out_valid && out_ready;
        fifo_rd_en  = !rst && drain_en && !fifo_empty
                      && ((occ < occ_t'(SKID_DEPTH)) || pop);
        in_flight_d = fifo_rd_en;
        beat_cnt_d  = beat_cnt_q;
        if (pop) begin
            beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_flight_q <= 1'b0;
            beat_cnt_q  <= '0;
        end else begin
            in_flight_q <= in_flight_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    skid_buf2 #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .push     (in_flight_q),
        .push_data(fifo_data_out),
        .pop      (pop),
        .head     (buf_head),
        .count    (buf_count)
    );

    assign out_valid = (buf_count != occ_t'(0));
    assign out_data  = buf_head;
    assign out_last  = out_valid && (beat_cnt_q == LAST_BEAT);
    assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a per-cycle vector table plus directed corner sequences,
// with a FIFO model and a stream scoreboard running throughout.
module tb_fifo_stream_reader;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned BURST_LEN = 16;
    localparam int unsigned CNT_W     = $clog2(BURST_LEN + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             drain_en;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data_out = '0;
    logic             fifo_rd_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic [CNT_W-1:0] beat_cnt;

    int checks = 0;
    int errors = 0;

    fifo_stream_reader #(
        .WIDTH    (WIDTH),
        .BURST_LEN(BURST_LEN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .drain_en     (drain_en),
        .fifo_empty   (fifo_empty),
        .fifo_data_out(fifo_data_out),
        .fifo_rd_en   (fifo_rd_en),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .beat_cnt     (beat_cnt)
    );

    always #5 clk = ~clk;

    // FIFO model with a registered read port
    logic [7:0]  fifo_mem [0:255];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_data_out <= fifo_mem[rd_ptr[7:0]];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    task automatic fifo_write(input logic [7:0] v);
        fifo_mem[wr_ptr[7:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Scoreboard: every accepted read is expected back on the stream, in order
    logic [7:0]  sb [$];
    int unsigned beat_m    = 0;
    int          pop_count = 0;
    logic        hold_q    = 1'b0;
    logic [7:0]  hold_data = '0;
    logic        hold_last = 1'b0;

    always @(negedge clk) begin
        if (fifo_empty) check("rd_en_while_empty", 32'(fifo_rd_en), 32'd0);
        if (hold_q) begin
            check("hold_data", 32'(out_data), 32'(hold_data));
            check("hold_last", 32'(out_last), 32'(hold_last));
        end
        hold_q    = !rst && out_valid && !out_ready;
        hold_data = out_data;
        hold_last = out_last;
        if (rst) begin
            sb.delete();
            beat_m = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_stray_word at %0t: got %0h expected no word", $time, out_data);
                end else begin
                    check("sb_data", 32'(out_data), 32'(sb.pop_front()));
                end
                check("sb_last", 32'(out_last), 32'(beat_m == BURST_LEN - 1));
                check("sb_beat", 32'(beat_cnt), 32'(beat_m));
                beat_m = (beat_m == BURST_LEN - 1) ? 0 : beat_m + 1;
                pop_count++;
            end
            if (fifo_rd_en && !fifo_empty) sb.push_back(fifo_mem[rd_ptr[7:0]]);
            check("occ_le_2", 32'(sb.size() <= 2), 32'd1);
        end
    end

    typedef struct {
        logic             rst;
        logic             drain;
        logic             ready;
        logic             e_rd;
        logic             e_valid;
        logic [7:0]       e_data;
        logic             e_last;
        logic [CNT_W-1:0] e_beat;
    } vec_t;

    vec_t vecs [$];

    task automatic add(input int r, input int d, input int y, input int erd,
                       input int ev, input int ed, input int el, input int eb);
        vec_t v;
        v.rst     = 1'(r);
        v.drain   = 1'(d);
        v.ready   = 1'(y);
        v.e_rd    = 1'(erd);
        v.e_valid = 1'(ev);
        v.e_data  = 8'(ed);
        v.e_last  = 1'(el);
        v.e_beat  = CNT_W'(eb);
        vecs.push_back(v);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wait_idle(input int max_cyc, input string name);
        int   n    = 0;
        logic idle = 1'b0;
        while (!idle && n < max_cyc) begin
            cyc();
            smp();
            n++;
            idle = fifo_empty && !out_valid && (sb.size() == 0);
        end
        check(name, 32'(idle), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        drain_en  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) fifo_write(8'(i));

        //   rst drn rdy | rd vld data last beat
        add(1, 1, 1,   0, 0, 8'h00, 0, 0);
        add(1, 1, 1,   0, 0, 8'h00, 0, 0);
        add(1, 1, 1,   0, 0, 8'h00, 0, 0);
        add(0, 1, 1,   1, 0, 8'h00, 0, 0);
        add(0, 1, 1,   1, 0, 8'h00, 0, 0);
        add(0, 1, 1,   1, 1, 8'h00, 0, 0);
        add(0, 1, 1,   1, 1, 8'h01, 0, 1);
        add(0, 1, 1,   1, 1, 8'h02, 0, 2);
        add(0, 1, 1,   1, 1, 8'h03, 0, 3);
        add(0, 1, 1,   1, 1, 8'h04, 0, 4);
        add(0, 1, 1,   1, 1, 8'h05, 0, 5);
        add(0, 1, 1,   1, 1, 8'h06, 0, 6);
        add(0, 1, 1,   1, 1, 8'h07, 0, 7);
        add(0, 1, 0,   0, 1, 8'h08, 0, 8);
        add(0, 1, 0,   0, 1, 8'h08, 0, 8);
        add(0, 1, 0,   0, 1, 8'h08, 0, 8);
        add(0, 1, 0,   0, 1, 8'h08, 0, 8);
        add(0, 1, 0,   0, 1, 8'h08, 0, 8);
        add(0, 1, 1,   1, 1, 8'h08, 0, 8);
        add(0, 1, 1,   1, 1, 8'h09, 0, 9);
        add(0, 1, 1,   1, 1, 8'h0A, 0, 10);
        add(0, 1, 1,   1, 1, 8'h0B, 0, 11);
        add(0, 1, 1,   1, 1, 8'h0C, 0, 12);
        add(0, 1, 1,   1, 1, 8'h0D, 0, 13);
        add(0, 1, 1,   1, 1, 8'h0E, 0, 14);
        add(0, 1, 1,   1, 1, 8'h0F, 1, 15);
        add(0, 1, 1,   1, 1, 8'h10, 0, 0);

        // reset, streaming start and backpressure, cycle by cycle
        for (int i = 0; i < vecs.size(); i++) begin
            cyc();
            rst       = vecs[i].rst;
            drain_en  = vecs[i].drain;
            out_ready = vecs[i].ready;
            smp();
            check($sformatf("vec%0d_rd_en", i),  32'(fifo_rd_en), 32'(vecs[i].e_rd));
            check($sformatf("vec%0d_valid", i),  32'(out_valid),  32'(vecs[i].e_valid));
            check($sformatf("vec%0d_data", i),   32'(out_data),   32'(vecs[i].e_data));
            check($sformatf("vec%0d_last", i),   32'(out_last),   32'(vecs[i].e_last));
            check($sformatf("vec%0d_beat", i),   32'(beat_cnt),   32'(vecs[i].e_beat));
        end

        // rest of the 32-word stream
        wait_idle(100, "t2_idle");
        check("t2_pops", 32'(pop_count), 32'd32);
        check("t2_beat", 32'(beat_cnt), 32'd0);

        // starvation gap between 0x45 and 0x46
        cyc();
        for (int i = 0; i < 6; i++) fifo_write(8'(8'h40 + i));
        wait_idle(50, "t4_first_idle");
        for (int i = 0; i < 3; i++) begin
            cyc();
            smp();
            check("t4_gap_valid", 32'(out_valid), 32'd0);
            check("t4_gap_beat", 32'(beat_cnt), 32'd6);
        end
        cyc();
        for (int i = 6; i < 16; i++) fifo_write(8'(8'h40 + i));
        wait_idle(60, "t4_idle");
        check("t4_pops", 32'(pop_count), 32'd48);
        check("t4_beat", 32'(beat_cnt), 32'd0);

        // drain_en dropped right after an accepted read
        cyc();
        drain_en = 1'b0;
        for (int i = 0; i < 8; i++) fifo_write(8'(8'h60 + i));
        smp();
        check("t5_off_rd", 32'(fifo_rd_en), 32'd0);
        cyc();
        drain_en = 1'b1;
        smp();
        check("t5_accept_rd", 32'(fifo_rd_en), 32'd1);
        cyc();
        drain_en = 1'b0;
        smp();
        check("t5_inflight_rd", 32'(fifo_rd_en), 32'd0);
        check("t5_inflight_valid", 32'(out_valid), 32'd0);
        cyc();
        smp();
        check("t5_word_valid", 32'(out_valid), 32'd1);
        check("t5_word_data", 32'(out_data), 32'h60);
        check("t5_word_rd", 32'(fifo_rd_en), 32'd0);
        cyc();
        smp();
        check("t5_after_valid", 32'(out_valid), 32'd0);
        check("t5_after_beat", 32'(beat_cnt), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            smp();
            check("t5_quiet_rd", 32'(fifo_rd_en), 32'd0);
        end

        // reset with a buffered word and a read in flight
        cyc();
        drain_en  = 1'b1;
        out_ready = 1'b0;
        smp();
        check("t6_a_rd", 32'(fifo_rd_en), 32'd1);
        cyc();
        smp();
        check("t6_b_rd", 32'(fifo_rd_en), 32'd1);
        check("t6_b_valid", 32'(out_valid), 32'd0);
        cyc();
        smp();
        check("t6_c_rd", 32'(fifo_rd_en), 32'd0);
        check("t6_c_data", 32'(out_data), 32'h61);
        cyc();
        out_ready = 1'b1;
        smp();
        check("t6_d_rd", 32'(fifo_rd_en), 32'd1);
        check("t6_d_data", 32'(out_data), 32'h61);
        cyc();
        out_ready = 1'b0;
        rst       = 1'b1;
        smp();
        check("t6_rst_rd", 32'(fifo_rd_en), 32'd0);
        cyc();
        rst       = 1'b0;
        out_ready = 1'b1;
        smp();
        check("t6_f_valid", 32'(out_valid), 32'd0);
        check("t6_f_beat", 32'(beat_cnt), 32'd0);
        check("t6_f_data", 32'(out_data), 32'd0);
        check("t6_f_rd", 32'(fifo_rd_en), 32'd1);
        cyc();
        smp();
        check("t6_g_valid", 32'(out_valid), 32'd0);
        cyc();
        smp();
        check("t6_h_valid", 32'(out_valid), 32'd1);
        check("t6_h_data", 32'(out_data), 32'h64);
        check("t6_h_beat", 32'(beat_cnt), 32'd0);
        wait_idle(50, "t6_idle");
        check("t6_pops", 32'(pop_count), 32'd54);
        check("t6_beat", 32'(beat_cnt), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
